// File: rtl/conv_pkg.sv
// conv_pkg: shared types and constants for the conv output collector.
// Holds the collector state encoding and the kept-pixel count helper.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WARMUP,
    CAPTURE,
    DRAIN,
    DONE
  } collector_state_t;

  localparam int WORD_SIZE_DEF = 8;
  localparam int ROW_SIZE_DEF  = 540;
  localparam int NUM_ROWS_DEF  = 360;

  // Valid 3x3 windows per frame: edge columns and rows are dropped.
  function automatic int kept_pixels(
    input int row_size,
    input int num_rows
  );
    return (row_size - 2) * (num_rows - 2);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO, DEPTH a power of two >= 2.
// A push into a full FIFO is refused unless a pop happens the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                 (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign dout = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr[PW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/conv_frame_collector.sv
// conv_frame_collector: aligns the conv output stream, drops edge windows and
// writes raster-order pixels through a FIFO. Stats: CONV_COLLECT_STATS_EN.
module conv_frame_collector
  import conv_pkg::*;
#(
  parameter int WORD_SIZE       = WORD_SIZE_DEF,
  parameter int ROW_SIZE        = ROW_SIZE_DEF,
  parameter int NUM_ROWS        = NUM_ROWS_DEF,
  parameter int FIRST_OUT_DELAY = 2*ROW_SIZE+6,
  parameter int FIFO_DEPTH      = 8,
  parameter int ADDR_W          =
    $clog2(kept_pixels(ROW_SIZE, NUM_ROWS))
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_start,
  input  logic [WORD_SIZE-1:0] pix_in,
  output logic                 wr_valid,
  input  logic                 wr_ready,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [WORD_SIZE-1:0] wr_data,
  output logic                 busy,
  output logic                 frame_done,
`ifdef CONV_COLLECT_STATS_EN
  output logic                 overflow,
  output logic [ADDR_W:0]      sat_count,
  output logic [ADDR_W:0]      zero_count
`else
  output logic                 overflow
`endif
);

  localparam int DLY_W = $clog2(FIRST_OUT_DELAY + 1);
  localparam int COL_W = $clog2(ROW_SIZE);
  localparam int ROW_W = $clog2(NUM_ROWS);
  localparam int FW    = ADDR_W + WORD_SIZE;

  localparam logic [DLY_W-1:0] DLY_LOAD =
    DLY_W'(FIRST_OUT_DELAY - 1);
  localparam logic [COL_W-1:0] KEEP_MAX = COL_W'(ROW_SIZE - 3);
  localparam logic [COL_W-1:0] COL_MAX  = COL_W'(ROW_SIZE - 1);
  localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(NUM_ROWS - 3);

  collector_state_t state;
  collector_state_t state_n;

  logic [DLY_W-1:0]     dly;
  logic [COL_W-1:0]     col;
  logic [ROW_W-1:0]     row;
  logic [ADDR_W-1:0]    addr;
  logic [WORD_SIZE-1:0] pix_q;

  logic start;
  logic keep;
  logic last_pos;
  logic drop;

  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [FW-1:0] fifo_din;
  logic [FW-1:0] fifo_dout;

  assign start    = (state == IDLE) && frame_start;
  assign keep     = (state == CAPTURE) && (col <= KEEP_MAX);
  assign last_pos = (state == CAPTURE) &&
                    (row == ROW_MAX) && (col == COL_MAX);
  assign fifo_pop = wr_ready && !fifo_empty;
  assign drop     = keep && fifo_full && !fifo_pop;
  assign fifo_din = {addr, pix_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (frame_start) state_n = WARMUP;
      WARMUP:  if (dly == '0)   state_n = CAPTURE;
      CAPTURE: if (last_pos)    state_n = DRAIN;
      DRAIN:   if (fifo_empty)  state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // pix_in is registered so the window arriving FIRST_OUT_DELAY cycles
  // after frame_start is the one seen in the first CAPTURE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly      <= '0;
      col      <= '0;
      row      <= '0;
      addr     <= '0;
      pix_q    <= '0;
      overflow <= 1'b0;
    end else begin
      pix_q <= pix_in;
      unique case (1'b1)
        start: begin
          dly      <= DLY_LOAD;
          col      <= '0;
          row      <= '0;
          addr     <= '0;
          overflow <= 1'b0;
        end
        (state == WARMUP): begin
          if (dly != '0) dly <= dly - DLY_W'(1);
        end
        (state == CAPTURE): begin
          if (col == COL_MAX) begin
            col <= '0;
            row <= row + ROW_W'(1);
          end else begin
            col <= col + COL_W'(1);
          end
          if (keep) addr <= addr + ADDR_W'(1);
          if (drop) overflow <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef CONV_COLLECT_STATS_EN
  localparam logic [WORD_SIZE-1:0] PIX_SAT = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count  <= '0;
      zero_count <= '0;
    end else if (start) begin
      sat_count  <= '0;
      zero_count <= '0;
    end else if (keep) begin
      if (pix_q == PIX_SAT)
        sat_count <= sat_count + (ADDR_W+1)'(1);
      if (pix_q == '0)
        zero_count <= zero_count + (ADDR_W+1)'(1);
    end
  end
`endif

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (keep),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign wr_valid   = !fifo_empty;
  assign wr_addr    = fifo_empty ? '0 : fifo_dout[FW-1:WORD_SIZE];
  assign wr_data    = fifo_empty ? '0 : fifo_dout[WORD_SIZE-1:0];
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

endmodule

// File: tb/tb_conv_frame_collector.sv
// tb_conv_frame_collector: directed frames on an 8x6 image, 4-deep FIFO.
// Build with CONV_COLLECT_STATS_EN to also check the saturation counters.
module tb_conv_frame_collector;

  localparam int WS   = 8;
  localparam int AW   = 5;
  localparam int KEPT = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          wr_ready = 1'b1;
  logic [WS-1:0] pix_in = '0;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [WS-1:0] wr_data;
  logic          busy;
  logic          frame_done;
  logic          overflow;
`ifdef CONV_COLLECT_STATS_EN
  logic [AW:0]   sat_count;
  logic [AW:0]   zero_count;
`endif

  conv_frame_collector #(
    .WORD_SIZE       (WS),
    .ROW_SIZE        (8),
    .NUM_ROWS        (6),
    .FIRST_OUT_DELAY (22),
    .FIFO_DEPTH      (4),
    .ADDR_W          (AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .pix_in      (pix_in),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .frame_done  (frame_done),
`ifdef CONV_COLLECT_STATS_EN
    .overflow    (overflow),
    .sat_count   (sat_count),
    .zero_count  (zero_count)
`else
    .overflow    (overflow)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  int cyc = 0;
  int mode = 0;
  bit force_sat = 1'b0;
  int fs_a = -1;
  int fs_b = -1;

  logic [AW-1:0] got_addr [$];
  logic [WS-1:0] got_data [$];
  int            done_pulses = 0;
  int            hold_err = 0;
  int            stall_cnt = 0;
  bit            busy_after = 1'b1;
  bit            prev_done = 1'b0;
  bit            prev_stall = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [WS-1:0] prev_data = '0;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (wr_valid && wr_ready) begin
        got_addr.push_back(wr_addr);
        got_data.push_back(wr_data);
      end
      if (prev_stall && (!wr_valid || wr_addr != prev_addr ||
                         wr_data != prev_data))
        hold_err++;
      prev_stall = wr_valid && !wr_ready;
      if (prev_stall) stall_cnt++;
      prev_addr = wr_addr;
      prev_data = wr_data;
      if (prev_done) busy_after = busy;
      prev_done = frame_done;
      if (frame_done) done_pulses++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    pix_in      = force_sat ? 8'hFF : cyc[7:0];
    frame_start = (cyc == fs_a) || (cyc == fs_b);
    case (mode)
      1:       wr_ready = !(cyc >= 24 && cyc <= 29);
      2:       wr_ready = (cyc <= 30) ? cyc[0] : 1'b1;
      default: wr_ready = 1'b1;
    endcase
  endtask

  task automatic start_frame(
    input int m,
    input bit sat,
    input int a,
    input int b
  );
    @(posedge clk);
    #1;
    mode        = m;
    force_sat   = sat;
    fs_a        = a;
    fs_b        = b;
    cyc         = 0;
    frame_start = 1'b1;
    pix_in      = sat ? 8'hFF : 8'h00;
    wr_ready    = 1'b1;
  endtask

  task automatic finish_frame(output int done_cyc);
    int d0 = done_pulses;
    int n  = 0;
    while (done_pulses == d0 && n < 300) begin
      step();
      n++;
    end
    check("frame_timeout", 32'(done_pulses == d0), 0);
    done_cyc = cyc - 1;
    repeat (3) step();
  endtask

  task automatic verify(
    input string       tag,
    input int          base,
    input logic [31:0] miss,
    input bit          sat
  );
    int idx = base;
    int n_exp = 0;
    for (int a = 0; a < KEPT; a++) if (!miss[a]) n_exp++;
    check({tag, "_count"}, got_addr.size() - base, n_exp);
    for (int a = 0; a < KEPT; a++) begin
      if (!miss[a]) begin
        if (idx < got_addr.size()) begin
          check({tag, "_addr"}, got_addr[idx], a);
          check({tag, "_data"}, got_data[idx],
                sat ? 255 : 22 + (a / 6) * 8 + a % 6);
        end
        idx++;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, wr_valid, 0);
    check({tag, "_addr"},  wr_addr, 0);
    check({tag, "_data"},  wr_data, 0);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  frame_done, 0);
    check({tag, "_ovf"},   overflow, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish, expected finish by 200000");
    $fatal(1);
  end

  initial begin
    int b;
    int d;
    int h;
    int s;
    int dc;

    #1;
    check_zero("rst");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    step();
    check("idle_busy", busy, 0);

    b = got_addr.size();
    d = done_pulses;
    start_frame(0, 1'b0, -1, -1);
    finish_frame(dc);
    check("f1_done_cyc", dc, 56);
    check("f1_pulses", done_pulses - d, 1);
    check("f1_busy_after", busy_after, 0);
    check("f1_ovf", overflow, 0);
    verify("f1", b, 32'h0, 1'b0);

    b = got_addr.size();
    start_frame(1, 1'b0, -1, -1);
    finish_frame(dc);
    check("f2_ovf", overflow, 1);
    verify("f2", b, 32'h30, 1'b0);

    b = got_addr.size();
    h = hold_err;
    s = stall_cnt;
    start_frame(2, 1'b0, -1, -1);
    finish_frame(dc);
    check("f3_ovf", overflow, 0);
    check("f3_hold", hold_err - h, 0);
    check("f3_stalls", 32'(stall_cnt > s), 1);
    verify("f3", b, 32'h0, 1'b0);

    b = got_addr.size();
    d = done_pulses;
    start_frame(0, 1'b0, 35, 56);
    finish_frame(dc);
    check("f4_done_cyc", dc, 56);
    check("f4_pulses", done_pulses - d, 1);
    check("f4_idle", busy, 0);
    verify("f4", b, 32'h0, 1'b0);

    start_frame(1, 1'b0, -1, -1);
    repeat (40) step();
    check("mid_busy", busy, 1);
    check("mid_valid", wr_valid, 1);
    check("mid_ovf", overflow, 1);
    rst_n = 1'b0;
    #2;
    check_zero("mid_rst");
    step();
    step();
    rst_n = 1'b1;
    step();

    b = got_addr.size();
    start_frame(0, 1'b0, -1, -1);
    finish_frame(dc);
    check("f5_ovf", overflow, 0);
    verify("f5", b, 32'h0, 1'b0);

    b = got_addr.size();
    start_frame(0, 1'b1, -1, -1);
    finish_frame(dc);
    verify("f6", b, 32'h0, 1'b1);
`ifdef CONV_COLLECT_STATS_EN
    check("f6_sat", sat_count, 24);
    check("f6_zero", zero_count, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
